// File: rtl/core_scheduler.sv
// -----------------------------------------------------------------------------
// core_scheduler
//
// Per-core instruction sequencer. Steps one core through the instruction
// phases and broadcasts the phase on core_state to every thread's ALU, LSU
// and PC/NZP unit. Owns the single current_pc shared by all threads of the
// core. On each UPDATE it reloads current_pc from the next_pc lane of the
// lowest-numbered active thread. done rises when a RET retires and stays set
// until reset.
//
// Optional feature macro: PC_DIVERGE_CHECK_EN
//   defined   : in UPDATE every active next_pc lane is compared against the
//               selected lane; a mismatch sets sticky diverge_err and ends
//               the block in DONE.
//   undefined : diverge_err is tied low and no comparator is built.
//
// Parameters
//   THREADS         threads per core
//   PC_W            program counter width
//
// Ports
//   clk             core clock, all state changes on rising edge
//   reset           synchronous active-high reset, dominates all inputs
//   enable          low freezes every register
//   start           level, sampled only in IDLE
//   thread_mask     active threads, sampled continuously
//   fetch_valid     fetcher holds the instruction at current_pc
//   decoded_mem_rd  current instruction is LDR
//   decoded_mem_wr  current instruction is STR
//   decoded_ret     current instruction is RET
//   lsu_busy        per-thread LSU request outstanding
//   next_pc         per-thread next PC, lane t = [t*PC_W +: PC_W]
//   core_state      broadcast phase (encoding in the table below)
//   current_pc      shared program counter
//   fetch_req       high exactly while core_state is FETCH (combinational)
//   done            block finished, sticky until reset
//   diverge_err     active lanes disagreed on next_pc (macro builds only)
//
// State table
//   state    | code | meaning
//   IDLE     | 000  | waiting for start
//   FETCH    | 001  | requesting instruction at current_pc
//   DECODE   | 010  | decoder working on the fetched instruction
//   REQUEST  | 011  | LSUs sample decoded_mem_* and issue
//   WAIT     | 100  | holding until outstanding LSU traffic drains
//   EXECUTE  | 101  | ALUs compute; PC units capture next_pc at the end
//   UPDATE   | 110  | retire: reload current_pc or finish
//   DONE     | 111  | terminal until reset
// -----------------------------------------------------------------------------
module core_scheduler #(
  parameter int THREADS = 4,
  parameter int PC_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic [THREADS-1:0]      thread_mask,
  input  logic                    fetch_valid,
  input  logic                    decoded_mem_rd,
  input  logic                    decoded_mem_wr,
  input  logic                    decoded_ret,
  input  logic [THREADS-1:0]      lsu_busy,
  input  logic [THREADS*PC_W-1:0] next_pc,
  output logic [2:0]              core_state,
  output logic [PC_W-1:0]         current_pc,
  output logic                    fetch_req,
  output logic                    done,
  output logic                    diverge_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_REQUEST = 3'b011,
    ST_WAIT    = 3'b100,
    ST_EXECUTE = 3'b101,
    ST_UPDATE  = 3'b110,
    ST_DONE    = 3'b111
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            done_q;
  logic            done_d;

  logic            mask_any;
  logic            mem_op;
  logic            lsu_pending;
  logic [PC_W-1:0] sel_pc;
  logic            sel_found;
  logic            lanes_diverge;

  assign mask_any    = |thread_mask;
  assign mem_op      = decoded_mem_rd | decoded_mem_wr;
  // Busy bits of inactive threads must never hold the core in WAIT.
  assign lsu_pending = |(lsu_busy & thread_mask);

  // next_pc lane of the lowest-indexed active thread.
  always_comb begin
    sel_pc    = '0;
    sel_found = 1'b0;
    for (int t = 0; t < THREADS; t++) begin
      if (thread_mask[t] && !sel_found) begin
        sel_pc    = next_pc[t*PC_W +: PC_W];
        sel_found = 1'b1;
      end
    end
  end

`ifdef PC_DIVERGE_CHECK_EN
  logic div_q;

  always_comb begin
    lanes_diverge = 1'b0;
    for (int t = 0; t < THREADS; t++) begin
      if (thread_mask[t] && (next_pc[t*PC_W +: PC_W] != sel_pc)) begin
        lanes_diverge = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 1'b0;
    end else if (enable && (state_q == ST_UPDATE) && mask_any && lanes_diverge) begin
      div_q <= 1'b1;
    end
  end

  assign diverge_err = div_q;
`else
  assign lanes_diverge = 1'b0;
  assign diverge_err   = 1'b0;
`endif

  // State register, together with the registers the FSM owns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. With enable low everything holds its value.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (mask_any) begin
              state_d = ST_FETCH;
              pc_d    = '0;
            end else begin
              // Nothing to run: finish immediately.
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (fetch_valid) begin
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_d = ST_REQUEST;
        end
        ST_REQUEST: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (!mem_op || !lsu_pending) begin
            state_d = ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          state_d = ST_UPDATE;
        end
        ST_UPDATE: begin
          // Divergence outranks RET; in every finishing case the PC holds.
          if (!mask_any || lanes_diverge || decoded_ret) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
            pc_d    = sel_pc;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs. fetch_req is the only output decoded straight from the state.
  always_comb begin
    core_state = state_q;
    current_pc = pc_q;
    done       = done_q;
    fetch_req  = (state_q == ST_FETCH);
  end

endmodule

// File: tb/tb_core_scheduler.sv
module tb_core_scheduler;

  localparam int THREADS = 4;
  localparam int PC_W    = 8;

`ifdef PC_DIVERGE_CHECK_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable;
  logic                    start;
  logic [THREADS-1:0]      thread_mask;
  logic                    fetch_valid;
  logic                    decoded_mem_rd;
  logic                    decoded_mem_wr;
  logic                    decoded_ret;
  logic [THREADS-1:0]      lsu_busy;
  logic [THREADS*PC_W-1:0] next_pc;
  logic [2:0]              core_state;
  logic [PC_W-1:0]         current_pc;
  logic                    fetch_req;
  logic                    done;
  logic                    diverge_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: observable values expected after the latest edge.
  int         m_state;
  logic [7:0] m_pc;
  bit         m_done;
  bit         m_div;
  bit         rnd_freeze;

  always #5 clk = ~clk;

  core_scheduler #(.THREADS(THREADS), .PC_W(PC_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .start          (start),
    .thread_mask    (thread_mask),
    .fetch_valid    (fetch_valid),
    .decoded_mem_rd (decoded_mem_rd),
    .decoded_mem_wr (decoded_mem_wr),
    .decoded_ret    (decoded_ret),
    .lsu_busy       (lsu_busy),
    .next_pc        (next_pc),
    .core_state     (core_state),
    .current_pc     (current_pc),
    .fetch_req      (fetch_req),
    .done           (done),
    .diverge_err    (diverge_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".state"},     32'(core_state),  32'(m_state));
    check_eq({tag, ".fetch_req"}, 32'(fetch_req),   32'(m_state == 1));
    check_eq({tag, ".pc"},        32'(current_pc),  32'(m_pc));
    check_eq({tag, ".done"},      32'(done),        32'(m_done));
    check_eq({tag, ".diverge"},   32'(diverge_err), 32'(m_div));
  endtask

  task automatic hold_cycles(input int n);
    enable = 1'b0;
    repeat (n) begin
      tick();
      check_all("freeze");
    end
    enable = 1'b1;
  endtask

  task automatic maybe_freeze;
    if (rnd_freeze && ($urandom_range(0, 7) == 0)) hold_cycles($urandom_range(1, 3));
  endtask

  task automatic advance(input int nxt, input string tag);
    tick();
    m_state = nxt;
    check_all(tag);
  endtask

  task automatic step(input int nxt, input string tag);
    maybe_freeze();
    advance(nxt, tag);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset   = 1'b0;
    m_state = 0;
    m_pc    = '0;
    m_done  = 1'b0;
    m_div   = 1'b0;
    check_all("reset");
  endtask

  task automatic launch(input logic [3:0] mask);
    start       = 1'b1;
    thread_mask = mask;
    maybe_freeze();
    m_pc = '0;
    advance(1, "launch");
    start = 1'b0;
  endtask

  function automatic logic [7:0] first_active(input logic [3:0] mask, input logic [31:0] lanes);
    for (int t = 0; t < THREADS; t++)
      if (mask[t]) return lanes[t*8 +: 8];
    return 8'h00;
  endfunction

  function automatic bit lanes_differ(input logic [3:0] mask, input logic [31:0] lanes);
    logic [7:0] ref_pc;
    ref_pc = first_active(mask, lanes);
    for (int t = 0; t < THREADS; t++)
      if (mask[t] && (lanes[t*8 +: 8] != ref_pc)) return 1'b1;
    return 1'b0;
  endfunction

  // One instruction starting from FETCH: fd cycles without fetch_valid,
  // nb extra WAIT cycles with active LSUs busy (memory ops only).
  task automatic run_instr(input logic i_rd, input logic i_wr, input logic i_ret,
                           input logic [3:0] mask, input int fd, input int nb,
                           input logic [3:0] stall, input logic [3:0] free,
                           input logic [31:0] lanes, input int freeze_wait,
                           input bit rst_exec);
    int nxt;
    thread_mask    = mask;
    decoded_mem_rd = i_rd;
    decoded_mem_wr = i_wr;
    decoded_ret    = i_ret;
    next_pc        = lanes;
    lsu_busy       = '0;
    fetch_valid    = 1'b0;
    repeat (fd) step(1, "fetch_wait");
    fetch_valid = 1'b1;
    step(2, "decode");
    fetch_valid = 1'($urandom_range(0, 1));
    step(3, "request");
    lsu_busy = (i_rd | i_wr) ? stall : 4'($urandom);
    step(4, "wait");
    if (freeze_wait > 0) hold_cycles(freeze_wait);
    if (i_rd | i_wr) begin
      repeat (nb) step(4, "wait_busy");
      lsu_busy = free;
    end
    step(5, "execute");
    if (rst_exec) begin
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      m_state = 0;
      m_pc    = '0;
      m_done  = 1'b0;
      m_div   = 1'b0;
      check_all("rst_exec");
      return;
    end
    step(6, "update");
    maybe_freeze();
    if (DIV_ON && lanes_differ(mask, lanes)) begin
      m_div  = 1'b1;
      m_done = 1'b1;
      nxt    = 7;
    end else if (i_ret) begin
      m_done = 1'b1;
      nxt    = 7;
    end else begin
      m_pc = first_active(mask, lanes);
      nxt  = 1;
    end
    advance(nxt, "retire");
  endtask

  task automatic check_done_sticky;
    repeat (4) begin
      start       = ~start;
      fetch_valid = ~fetch_valid;
      step(7, "done_hold");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [3:0] mask;
    logic [3:0] stall;
    logic [31:0] lanes;
    logic [7:0] v;
    int idx;
    logic rd, wr, rt;

    rnd_freeze     = 1'b0;
    reset          = 1'b1;
    enable         = 1'b1;
    start          = 1'b0;
    thread_mask    = 4'b1111;
    fetch_valid    = 1'b0;
    decoded_mem_rd = 1'b0;
    decoded_mem_wr = 1'b0;
    decoded_ret    = 1'b0;
    lsu_busy       = '0;
    next_pc        = '0;

    apply_reset(2);
    step(0, "idle_hold");
    step(0, "idle_hold");

    fetch_valid = 1'b1;
    launch(4'b1111);

    c0 = cyc;
    run_instr(0, 0, 0, 4'b1111, 0, 0, 4'b0000, 4'b0000, {4{8'h01}}, 0, 0);
    check_eq("alu_latency", 32'(cyc - c0), 32'd6);

    run_instr(1, 0, 0, 4'b0011, 0, 3, 4'b1110, 4'b1100, 32'hAB990505, 0, 0);
    run_instr(0, 1, 0, 4'b1111, 1, 2, 4'b0001, 4'b0000, {4{8'hFF}}, 4, 0);
    run_instr(0, 0, 0, 4'b1111, 0, 0, 4'b0000, 4'b0000, {4{8'h00}}, 0, 0);
    run_instr(0, 0, 0, 4'b1000, 0, 0, 4'b0000, 4'b0000, 32'h30112233, 0, 0);
    run_instr(0, 0, 0, 4'b1111, 0, 0, 4'b0000, 4'b0000, {4{8'h44}}, 0, 1);

    fetch_valid = 1'b1;
    launch(4'b0101);
    run_instr(0, 0, 0, 4'b0101, 0, 0, 4'b0000, 4'b0000, 32'h77225510, 0, 0);
    if (m_state == 1)
      run_instr(0, 0, 1, 4'b1111, 0, 0, 4'b0000, 4'b0000, {4{8'h5A}}, 0, 0);
    check_done_sticky();
    apply_reset(1);

    start       = 1'b1;
    thread_mask = 4'b0000;
    tick();
    check_eq("idle_mask0.state", 32'(core_state), 32'd7);
    start = 1'b0;
    apply_reset(1);

    rnd_freeze = 1'b1;
    for (int blk = 0; blk < 6; blk++) begin
      apply_reset($urandom_range(1, 3));
      fetch_valid = 1'($urandom_range(0, 1));
      launch(4'($urandom_range(1, 15)));
      start = 1'($urandom_range(0, 1));
      for (int i = 0; i < 20 && m_state != 7; i++) begin
        mask = 4'($urandom_range(1, 15));
        rd   = ($urandom_range(0, 2) == 0);
        wr   = !rd && ($urandom_range(0, 3) == 0);
        rt   = ($urandom_range(0, 11) == 0);
        do idx = $urandom_range(0, 3); while (!mask[idx]);
        stall = 4'($urandom) | (4'b0001 << idx);
        v     = 8'($urandom);
        lanes = {4{v}};
        for (int t = 0; t < THREADS; t++)
          if (!mask[t]) lanes[t*8 +: 8] = 8'($urandom);
        if ($urandom_range(0, 5) == 0) lanes = $urandom;
        run_instr(rd, wr, rt, mask, $urandom_range(0, 2), $urandom_range(0, 3),
                  stall, 4'($urandom) & ~mask, lanes, 0, 0);
      end
      if (m_state == 7) check_done_sticky();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
